// File: rtl/acorn_prng_gen_if.sv
// acorn_prng_gen_if: seed intake, enable and output stream of the ACORN generator.
// Latency: none, wires only.
// Backpressure: out_valid/out_ready on the word stream; seed_ready is always-accept after reset.
interface acorn_prng_gen_if #(
    parameter int WIDTH = 16
) ();
    logic             seed_valid;
    logic             seed_ready;
    logic [WIDTH-1:0] seed_data;
    logic             enable;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;

    // Environment side: offers seeds, controls enable, consumes words.
    modport master (
        output seed_valid, seed_data, enable, out_ready,
        input  seed_ready, out_valid, out_data, busy
    );

    // Generator side.
    modport slave (
        input  seed_valid, seed_data, enable, out_ready,
        output seed_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/acorn_prng_gen.sv
// acorn_prng_gen: ACORN PRNG (order ORDER, modulus 2^WIDTH), one stage per cycle, one word per ORDER+1 cycles.
// Latency: first word ORDER cycles after seed accept (+WARMUP*(ORDER+1) when ACORN_WARMUP_EN is defined).
// Backpressure: word held in HOLD until out_ready; a seed load pre-empts every state. Optional macro: ACORN_WARMUP_EN.
module acorn_prng_gen #(
    parameter int WIDTH  = 16,
    parameter int ORDER  = 8,
    parameter int WARMUP = 16
) (
    input  logic               clk,
    input  logic               reset,
    acorn_prng_gen_if.slave    bus
);
    localparam int SW = $clog2(ORDER + 1);

    typedef enum logic [1:0] {IDLE, CALC, HOLD, PAUSE} state_t;

    if (WIDTH < 4 || ORDER < 2 || ORDER > 32 || WARMUP < 0) begin : g_bad_cfg
        $error("acorn_prng_gen: unsupported WIDTH/ORDER/WARMUP");
    end

    state_t           state_q;
    logic [WIDTH-1:0] seed_q;
    logic [WIDTH-1:0] y_q [1:ORDER];
    logic [WIDTH-1:0] sum [1:ORDER];
    logic [SW-1:0]    stage_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             busy_q;
    logic             seed_ready_q;
    logic             warm_done;

    // Stage k adds the already-updated lower stage (the seed for stage 1).
    for (genvar k = 1; k <= ORDER; k++) begin : g_stage
        if (k == 1) begin : g_first
            assign sum[k] = y_q[k] + seed_q;
        end else begin : g_rest
            assign sum[k] = y_q[k] + y_q[k-1];
        end
    end

`ifdef ACORN_WARMUP_EN
    localparam int WW = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);
    logic [WW-1:0] warm_q;
    assign warm_done = (int'(warm_q) >= WARMUP);

    // Count discarded iterations since the last seed load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            warm_q <= '0;
        end else if (bus.seed_valid) begin
            warm_q <= '0;
        end else if (state_q == CALC && stage_q == SW'(ORDER) && !warm_done) begin
            warm_q <= warm_q + WW'(1);
        end
    end
`else
    assign warm_done = 1'b1;
`endif

    // Main FSM: seed load, per-stage accumulation, output hold and pause.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            seed_q       <= '0;
            stage_q      <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            busy_q       <= 1'b0;
            seed_ready_q <= 1'b0;
            for (int k = 1; k <= ORDER; k++) y_q[k] <= '0;
        end else begin
            seed_ready_q <= 1'b1;
            if (bus.seed_valid) begin
                // Forcing the LSB keeps the seed coprime to 2^WIDTH.
                seed_q      <= {bus.seed_data[WIDTH-1:1], 1'b1};
                for (int k = 1; k <= ORDER; k++) y_q[k] <= '0;
                stage_q     <= SW'(1);
                out_valid_q <= 1'b0;
                busy_q      <= 1'b1;
                state_q     <= CALC;
            end else begin
                case (state_q)
                    IDLE: ;
                    CALC: begin
                        for (int k = 1; k <= ORDER; k++) begin
                            if (stage_q == SW'(k)) y_q[k] <= sum[k];
                        end
                        if (stage_q == SW'(ORDER)) begin
                            if (warm_done) begin
                                out_data_q  <= sum[ORDER];
                                out_valid_q <= 1'b1;
                                busy_q      <= 1'b0;
                                state_q     <= HOLD;
                            end else begin
                                // Stage 0 is an idle slot standing in for the handshake
                                // cycle, so discarded iterations keep the visible cadence.
                                stage_q <= '0;
                            end
                        end else begin
                            stage_q <= stage_q + SW'(1);
                        end
                    end
                    HOLD: begin
                        if (bus.out_ready) begin
                            out_valid_q <= 1'b0;
                            stage_q     <= SW'(1);
                            busy_q      <= bus.enable;
                            state_q     <= bus.enable ? CALC : PAUSE;
                        end
                    end
                    PAUSE: begin
                        if (bus.enable) begin
                            busy_q  <= 1'b1;
                            state_q <= CALC;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.seed_ready = seed_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_acorn_prng_gen.sv
// tb_acorn_prng_gen: directed checks of the ACORN generator in three configurations.
// Latency: n/a.
// Backpressure: exercises HOLD stall, pause and seed pre-emption.
module tb_acorn_prng_gen;
    logic clk;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc;
    logic [15:0] dat;
    logic ok;

    acorn_prng_gen_if #(.WIDTH(16)) b16 ();
    acorn_prng_gen_if #(.WIDTH(8))  b8  ();
    acorn_prng_gen_if #(.WIDTH(16)) bw  ();

    acorn_prng_gen #(.WIDTH(16), .ORDER(4), .WARMUP(0)) u16 (.clk(clk), .reset(reset), .bus(b16));
    acorn_prng_gen #(.WIDTH(8),  .ORDER(4), .WARMUP(0)) u8  (.clk(clk), .reset(reset), .bus(b8));
    acorn_prng_gen #(.WIDTH(16), .ORDER(4), .WARMUP(2)) uw  (.clk(clk), .reset(reset), .bus(bw));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_vld(input int sel);
        case (sel)
            0:       return b16.out_valid;
            1:       return b8.out_valid;
            default: return bw.out_valid;
        endcase
    endfunction

    function automatic logic [15:0] get_dat(input int sel);
        case (sel)
            0:       return b16.out_data;
            1:       return {8'h00, b8.out_data};
            default: return bw.out_data;
        endcase
    endfunction

    // Advance negedge by negedge until out_valid is seen; returns cycles taken.
    task automatic wait_word(input int sel, output int c, output logic [15:0] d);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (get_vld(sel) !== 1'b1 && c < 60);
        d = get_dat(sel);
    endtask

    initial begin
        reset = 1'b0;
        b16.seed_valid = 0; b16.seed_data = '0; b16.enable = 0; b16.out_ready = 0;
        b8.seed_valid  = 0; b8.seed_data  = '0; b8.enable  = 0; b8.out_ready  = 0;
        bw.seed_valid  = 0; bw.seed_data  = '0; bw.enable  = 0; bw.out_ready  = 0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", b16.out_valid, 0);
        chk("rst_out_data", b16.out_data, 0);
        chk("rst_busy", b16.busy, 0);
        chk("rst_seed_ready", b16.seed_ready, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("seed_ready_after_rst", b16.seed_ready, 1);

        // Seed 1, free running: 1, 5, F, 23 with period 5
        b16.enable = 1; b16.out_ready = 1; b16.seed_data = 16'h0001; b16.seed_valid = 1;
        @(negedge clk);
        b16.seed_valid = 0;
        chk("busy_in_calc", b16.busy, 1);
        wait_word(0, cyc, dat);
        chk("lat_seed1", cyc, 4);
        chk("w1_seed1", dat, 16'h0001);
        chk("busy_in_hold", b16.busy, 0);
        wait_word(0, cyc, dat);
        chk("period_w2", cyc, 5);
        chk("w2_seed1", dat, 16'h0005);
        wait_word(0, cyc, dat);
        chk("w3_seed1", dat, 16'h000F);
        wait_word(0, cyc, dat);
        chk("period_w4", cyc, 5);
        chk("w4_seed1", dat, 16'h0023);

        // Even seed 4 loaded together with a HOLD handshake: seed wins, becomes 5
        b16.seed_data = 16'h0004; b16.seed_valid = 1;
        @(negedge clk);
        b16.seed_valid = 0;
        chk("seed_hs_valid_drop", b16.out_valid, 0);
        wait_word(0, cyc, dat);
        chk("lat_seed4", cyc, 4);
        chk("w1_seed4", dat, 16'h0005);
        wait_word(0, cyc, dat);
        chk("w2_seed4", dat, 16'h0019);

        // Stall in HOLD for 10 cycles
        b16.out_ready = 0;
        ok = 1;
        repeat (10) begin
            @(negedge clk);
            if (b16.out_valid !== 1'b1 || b16.out_data !== 16'h0019) ok = 0;
        end
        chk("hold_stable", ok, 1);

        // Consume with enable=0 -> PAUSE, nothing new
        b16.enable = 0; b16.out_ready = 1;
        @(negedge clk);
        chk("pause_valid", b16.out_valid, 0);
        ok = 1;
        repeat (8) begin
            @(negedge clk);
            if (b16.out_valid !== 1'b0 || b16.busy !== 1'b0) ok = 0;
        end
        chk("pause_quiet", ok, 1);
        b16.enable = 1;
        wait_word(0, cyc, dat);
        chk("resume_lat", cyc, 5);
        chk("w3_seed4_resumed", dat, 16'h004B);

        // Seed mid-CALC: partial iteration dropped, restart at word 1
        repeat (2) @(negedge clk);
        chk("midcalc_busy", b16.busy, 1);
        b16.seed_data = 16'h0001; b16.seed_valid = 1;
        @(negedge clk);
        b16.seed_valid = 0;
        wait_word(0, cyc, dat);
        chk("lat_midcalc", cyc, 4);
        chk("w1_midcalc", dat, 16'h0001);
        wait_word(0, cyc, dat);
        chk("w2_midcalc", dat, 16'h0005);

        // Asynchronous reset in the middle of CALC
        repeat (2) @(negedge clk);
        chk("pre_reset_data", b16.out_data, 16'h0005);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_valid", b16.out_valid, 0);
        chk("async_rst_data", b16.out_data, 0);
        chk("async_rst_busy", b16.busy, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // 8-bit instance: IDLE ignores enable/out_ready, then wrap-around
        b8.enable = 1; b8.out_ready = 1;
        ok = 1;
        repeat (6) begin
            @(negedge clk);
            if (b8.out_valid !== 1'b0 || b8.busy !== 1'b0) ok = 0;
        end
        chk("idle_ignores_enable", ok, 1);
        b8.seed_data = 8'hFF; b8.seed_valid = 1;
        @(negedge clk);
        b8.seed_valid = 0;
        wait_word(1, cyc, dat);
        chk("lat_w8", cyc, 4);
        chk("w1_w8", dat, 16'h00FF);
        wait_word(1, cyc, dat);
        chk("w2_w8_wrap", dat, 16'h00FB);

        // Warm-up instance (WARMUP=2)
        bw.enable = 1; bw.out_ready = 1; bw.seed_data = 16'h0001; bw.seed_valid = 1;
        @(negedge clk);
        bw.seed_valid = 0;
        wait_word(2, cyc, dat);
`ifdef ACORN_WARMUP_EN
        chk("lat_warmup", cyc, 14);
        chk("w1_warmup", dat, 16'h000F);
        wait_word(2, cyc, dat);
        chk("period_warmup", cyc, 5);
        chk("w2_warmup", dat, 16'h0023);
`else
        chk("lat_nowarmup", cyc, 4);
        chk("w1_nowarmup", dat, 16'h0001);
        wait_word(2, cyc, dat);
        chk("period_nowarmup", cyc, 5);
        chk("w2_nowarmup", dat, 16'h0005);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
